// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline buffer: registers fetched words and merges an
// instruction with its trailing 16-bit immediate word into one decode packet.
module if_id_stage #(
  parameter int          IMM_FLAG_BIT = 15,
  parameter logic [15:0] NOP_WORD     = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_next_pc,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_imm,
  output logic        out_has_imm,
  output logic [31:0] out_pc,
  output logic [31:0] out_next_pc,
  output logic        imm_pending
);

  typedef enum logic {
    S_INSTR = 1'b0,
    S_IMM   = 1'b1
  } stateT;

  stateT       state, stateNext;
  logic [15:0] pendingInstr, pendingInstrNext;
  logic [31:0] pendingPc, pendingPcNext;
  logic        validNext, hasImmNext;
  logic [15:0] instrNext, immNext;
  logic [31:0] pcNext, nextPcNext;

  // Handshake: a word is consumed only in a cycle with in_valid=1, stall=0 and
  // flush=0; while stalled, fetch must keep presenting the same word.
  always_comb begin
    stateNext        = state;
    pendingInstrNext = pendingInstr;
    pendingPcNext    = pendingPc;
    validNext        = out_valid;
    instrNext        = out_instr;
    immNext          = out_imm;
    hasImmNext       = out_has_imm;
    pcNext           = out_pc;
    nextPcNext       = out_next_pc;

    if (flush) begin
      stateNext        = S_INSTR;
      pendingInstrNext = '0;
      pendingPcNext    = '0;
      validNext        = 1'b0;
      instrNext        = NOP_WORD;
      immNext          = '0;
      hasImmNext       = 1'b0;
    end else if (!stall) begin
      // Bubble unless this cycle completes a packet; PCs keep their last value.
      validNext  = 1'b0;
      instrNext  = NOP_WORD;
      immNext    = '0;
      hasImmNext = 1'b0;
      if (in_valid) begin
        case (state)
          S_INSTR: begin
            if (in_instr[IMM_FLAG_BIT]) begin
              pendingInstrNext = in_instr;
              pendingPcNext    = in_pc;
              stateNext        = S_IMM;
            end else begin
              validNext  = 1'b1;
              instrNext  = in_instr;
              pcNext     = in_pc;
              nextPcNext = in_next_pc;
            end
          end
          S_IMM: begin
            // The word here is data, whatever its flag bit says.
            validNext  = 1'b1;
            instrNext  = pendingInstr;
            immNext    = in_instr;
            hasImmNext = 1'b1;
            pcNext     = pendingPc;
            nextPcNext = in_next_pc;
            stateNext  = S_INSTR;
          end
          default: stateNext = S_INSTR;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_INSTR;
      pendingInstr <= '0;
      pendingPc    <= '0;
      out_valid    <= 1'b0;
      out_instr    <= NOP_WORD;
      out_imm      <= '0;
      out_has_imm  <= 1'b0;
      out_pc       <= '0;
      out_next_pc  <= '0;
    end else begin
      state        <= stateNext;
      pendingInstr <= pendingInstrNext;
      pendingPc    <= pendingPcNext;
      out_valid    <= validNext;
      out_instr    <= instrNext;
      out_imm      <= immNext;
      out_has_imm  <= hasImmNext;
      out_pc       <= pcNext;
      out_next_pc  <= nextPcNext;
    end
  end

  assign imm_pending = (state == S_IMM);

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: each driven cycle pushes its expected decode packet
// (with a care mask) and the packet is popped and compared one clock later.
module tb_if_id_stage;

  localparam int PW = 99;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_next_pc;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_imm;
  logic        out_has_imm;
  logic [31:0] out_pc;
  logic [31:0] out_next_pc;
  logic        imm_pending;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] msk_q[$];
  string         tag_q[$];

  int checks = 0;
  int errors = 0;

  if_id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_next_pc (in_next_pc),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_imm    (out_imm),
    .out_has_imm(out_has_imm),
    .out_pc     (out_pc),
    .out_next_pc(out_next_pc),
    .imm_pending(imm_pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packet layout: {valid, instr, imm, has_imm, pc, next_pc, imm_pending}
  function automatic logic [PW-1:0] pk(input logic v, input logic [15:0] i,
                                       input logic [15:0] im, input logic h,
                                       input logic [31:0] p, input logic [31:0] np,
                                       input logic pe);
    return {v, i, im, h, p, np, pe};
  endfunction

  logic [PW-1:0] m_all, m_bub, m_fl;

  task automatic check_eq(input string tag, input logic [PW-1:0] obs,
                          input logic [PW-1:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, expv);
    end
  endtask

  // driver: one clock of stimulus plus its expected packet
  task automatic step(input string tag, input logic r, input logic s, input logic f,
                      input logic v, input logic [15:0] ins, input logic [31:0] pc,
                      input logic [31:0] npc, input logic [PW-1:0] e,
                      input logic [PW-1:0] m);
    logic [PW-1:0] obs, ev, mv;
    string         t;
    exp_q.push_back(e);
    msk_q.push_back(m);
    tag_q.push_back(tag);
    rst        = r;
    stall      = s;
    flush      = f;
    in_valid   = v;
    in_instr   = ins;
    in_pc      = pc;
    in_next_pc = npc;
    @(posedge clk);
    #1;
    obs = {out_valid, out_instr, out_imm, out_has_imm, out_pc, out_next_pc, imm_pending};
    ev  = exp_q.pop_front();
    mv  = msk_q.pop_front();
    t   = tag_q.pop_front();
    check_eq(t, obs & mv, ev & mv);
  endtask

  initial begin
    logic [15:0] w;
    m_all = '1;
    m_bub = pk(1'b1, 16'hFFFF, 16'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    m_fl  = pk(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0, 32'h0, 1'b1);

    // reset then plain stream
    step("rst0", 0, 0, 0, 1, 16'h8765, 32'h5, 32'h6, pk(0, 16'h0, 16'h0, 0, 0, 0, 0), m_all);
    step("rst1", 0, 0, 0, 0, 16'h0, 32'h0, 32'h0, pk(0, 16'h0, 16'h0, 0, 0, 0, 0), m_all);
    step("plain1", 1, 0, 0, 1, 16'h1234, 32'h20, 32'h21, pk(1, 16'h1234, 0, 0, 32'h20, 32'h21, 0), m_all);
    step("plain2", 1, 0, 0, 1, 16'h2345, 32'h21, 32'h22, pk(1, 16'h2345, 0, 0, 32'h21, 32'h22, 0), m_all);

    // immediate pair
    step("pair_bub", 1, 0, 0, 1, 16'h8A00, 32'h30, 32'h31, pk(0, 16'h0, 0, 0, 0, 0, 1), m_bub);
    step("pair_out", 1, 0, 0, 1, 16'h00FF, 32'h31, 32'h32, pk(1, 16'h8A00, 16'h00FF, 1, 32'h30, 32'h32, 0), m_all);

    // stall in S_IMM with changing input
    step("stl_bub", 1, 0, 0, 1, 16'h8A00, 32'h40, 32'h41, pk(0, 16'h0, 0, 0, 0, 0, 1), m_bub);
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom_range(0, 65535));
      step("stl_hold", 1, 1, 0, 1, w, 32'($urandom), 32'($urandom), pk(0, 16'h0, 0, 0, 0, 0, 1), m_bub);
    end
    step("stl_out", 1, 0, 0, 1, 16'h0042, 32'h41, 32'h42, pk(1, 16'h8A00, 16'h0042, 1, 32'h40, 32'h42, 0), m_all);

    // flush wins over stall
    step("fl_bub", 1, 0, 0, 1, 16'h8C00, 32'h50, 32'h51, pk(0, 16'h0, 0, 0, 0, 0, 1), m_bub);
    step("fl_stall", 1, 1, 1, 1, 16'h1234, 32'h51, 32'h52, pk(0, 16'h0, 16'h0, 0, 0, 0, 0), m_fl);
    step("fl_new", 1, 0, 0, 1, 16'h8000, 32'h60, 32'h61, pk(0, 16'h0, 0, 0, 0, 0, 1), m_bub);
    step("fl_out", 1, 0, 0, 1, 16'h0007, 32'h61, 32'h62, pk(1, 16'h8000, 16'h0007, 1, 32'h60, 32'h62, 0), m_all);

    // reset while waiting for an immediate
    step("mr_bub", 1, 0, 0, 1, 16'h8D00, 32'h70, 32'h71, pk(0, 16'h0, 0, 0, 0, 0, 1), m_bub);
    step("mr_rst", 0, 0, 0, 1, 16'h0099, 32'h71, 32'h72, pk(0, 16'h0, 16'h0, 0, 0, 0, 0), m_all);
    step("mr_next", 1, 0, 0, 1, 16'h1111, 32'h80, 32'h81, pk(1, 16'h1111, 0, 0, 32'h80, 32'h81, 0), m_all);

    // fetch gaps between instruction and immediate
    step("gap_bub", 1, 0, 0, 1, 16'h8B00, 32'h90, 32'h91, pk(0, 16'h0, 0, 0, 0, 0, 1), m_bub);
    step("gap0", 1, 0, 0, 0, 16'hFFFF, 32'hDEAD, 32'hBEEF, pk(0, 16'h0, 0, 0, 0, 0, 1), m_bub);
    step("gap1", 1, 0, 0, 0, 16'h8001, 32'hDEAD, 32'hBEEF, pk(0, 16'h0, 0, 0, 0, 0, 1), m_bub);
    step("gap_out", 1, 0, 0, 1, 16'h5555, 32'h91, 32'h92, pk(1, 16'h8B00, 16'h5555, 1, 32'h90, 32'h92, 0), m_all);
    step("gap_idle", 1, 0, 0, 0, 16'h1234, 32'h0, 32'h0, pk(0, 16'h0, 0, 0, 0, 0, 0), m_bub);

    // flagged word in the immediate slot is plain data
    step("flg_bub", 1, 0, 0, 1, 16'h9000, 32'hA0, 32'hA1, pk(0, 16'h0, 0, 0, 0, 0, 1), m_bub);
    step("flg_out", 1, 0, 0, 1, 16'h8123, 32'hA1, 32'hA2, pk(1, 16'h9000, 16'h8123, 1, 32'hA0, 32'hA2, 0), m_all);

    // random plain instruction stream
    for (int i = 0; i < 8; i++) begin
      logic [31:0] p;
      w = 16'($urandom_range(0, 16'h7FFF));
      p = $urandom;
      step("rnd_plain", 1, 0, 0, 1, w, p, p + 32'd1, pk(1, w, 0, 0, p, p + 32'd1, 0), m_all);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Pipeline buffer between the fetch stage and the decode stage. It registers each fetched 16-bit word with its PC and next-PC. When an instruction carries a 16-bit immediate in the following word, it assembles the two fetched words into one decode packet. It also applies stall (hold) and flush (bubble insertion on jump/interrupt) so decode always sees either one complete instruction or a NOP bubble.

Parameters:
IMM_FLAG_BIT, 15, bit of the instruction word that marks "immediate word follows"
NOP_WORD, 16'h0000, instruction value driven while out_valid=0 after reset/flush

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-low reset (rst=0 at posedge resets)
stall  input  1  hold all state and outputs this cycle
flush  input  1  discard buffered/pending content (jump taken or interrupt)
in_valid  input  1  fetch word on in_instr is meaningful this cycle
in_instr  input  16  fetched word (instruction or immediate)
in_pc  input  32  address of in_instr
in_next_pc  input  32  address following in_instr
out_valid  output  1  decode packet valid
out_instr  output  16  instruction word to decode
out_imm  output  16  immediate word (0 when instruction has none)
out_has_imm  output  1  out_instr used an immediate
out_pc  output  32  address of out_instr
out_next_pc  output  32  return/fall-through address after the full instruction
imm_pending  output  1  FSM is waiting for an immediate word (hazard/interrupt unit visibility)

Behaviour:
- All outputs are registered. Latency from fetch word to decode packet is 1 clock for plain instructions and 1 clock after the immediate word for two-word instructions.
- Reset (rst=0 at posedge) has highest priority. State goes to S_INSTR. out_valid=0, out_instr=NOP_WORD, out_imm=0, out_has_imm=0, out_pc=0, out_next_pc=0, imm_pending=0. Pending registers are cleared.
- Flush has the next priority and wins over stall. State goes to S_INSTR, pending is dropped, out_valid=0, out_instr=NOP_WORD, out_has_imm=0, out_imm=0. out_pc and out_next_pc hold their values.
- Stall (with no reset and no flush): every register, including the FSM state, holds. Input is ignored; fetch re-presents the same word.
- FSM states:
  - S_INSTR: expecting an instruction word.
  - S_IMM: an instruction is held in pending_instr/pending_pc and the immediate word is expected.
- S_INSTR, in_valid=1, in_instr[IMM_FLAG_BIT]=0: next cycle out_valid=1, out_instr=in_instr, out_imm=0, out_has_imm=0, out_pc=in_pc, out_next_pc=in_next_pc. State stays S_INSTR.
- S_INSTR, in_valid=1, in_instr[IMM_FLAG_BIT]=1: pending_instr<=in_instr and pending_pc<=in_pc. Next cycle out_valid=0 and out_instr=NOP_WORD (bubble). State goes to S_IMM and imm_pending=1.
- S_IMM, in_valid=1: the word is treated as data regardless of bit IMM_FLAG_BIT. Next cycle out_valid=1, out_instr=pending_instr, out_imm=in_instr, out_has_imm=1, out_pc=pending_pc, out_next_pc=in_next_pc. State goes to S_INSTR and imm_pending=0.
- in_valid=0 in either state: next cycle out_valid=0 and out_instr=NOP_WORD. State and pending registers are unchanged.
- Reset mid-operation (in S_IMM): pending is discarded, no packet is emitted, and the next word is decoded as an instruction.
- Stall in S_IMM: the FSM stays in S_IMM with imm_pending=1 and the pending contents intact.
- No arithmetic is performed. PC values pass through unmodified at 32 bits.

Test Plan:
- Reset then plain stream: rst=0 for 2 clocks, then words 16'h1234@pc 0x20 and 16'h2345@pc 0x21 back-to-back. Required: out_valid=0 and all outputs 0 during reset. Next, out_instr=1234 with out_pc=0x20, then out_instr=2345 with out_pc=0x21, out_has_imm=0, each 1 clock after input.
- Immediate pair: word 16'h8A00@0x30, then 16'h00FF@0x31 (next_pc 0x32). Required: bubble cycle with out_valid=0 and imm_pending=1. Then out_valid=1, out_instr=8A00, out_imm=00FF, out_has_imm=1, out_pc=0x30, out_next_pc=0x32.
- Stall in S_IMM: after 16'h8A00, hold stall=1 for 3 clocks with in_instr changing. Required: outputs and imm_pending=1 frozen. After release, 16'h0042 completes the pair with out_imm=0042.
- Flush vs stall: in S_IMM assert flush=1 and stall=1 together. Required: next cycle out_valid=0, imm_pending=0. A following 16'h8000 is treated as a new instruction and enters S_IMM.
- Mid-op reset: in S_IMM assert rst=0 for one clock. Required: all outputs are at reset values. The next word 16'h1111 emits directly with out_has_imm=0.
- Gaps: in_valid=0 between instruction 16'h8B00 and its immediate for 2 clocks. Required: out_valid=0 for those clocks and the pair still assembles correctly.
